multicycle_ctrl: RTL

Control FSM for the multicycle LEGv8 datapath: sequences each instruction through fetch, decode, execute, memory and write-back, driving register file, ALU, signext-fed ALU operand selection, PC and memory enables. It sits beside the datapath and takes only the instruction opcode field, the ALU zero flag and a memory ready handshake. Unsupported opcodes stop the machine in a halted state until reset. It also counts retired instructions for the bench and debug.

---
 rtl/ctrl_pkg.sv | 60 ++++++
 rtl/op_classify.sv | 21 ++
 rtl/multicycle_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle LEGv8 control FSM.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXEC_R   = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_HALT     = 4'd9
   } state_t;

   typedef enum logic [2:0] {
      CLS_LOAD,
      CLS_STORE,
      CLS_CBZ,
      CLS_RTYPE,
      CLS_ILLEGAL
   } instr_class_t;

   localparam logic [10:0] OP_LDUR  = 11'b11111000010;
   localparam logic [10:0] OP_STUR  = 11'b11111000000;
   localparam logic [10:0] OP_CBZ   = 11'b10110100000;
   localparam logic [10:0] CBZ_MASK = 11'b11111111000;
   localparam logic [10:0] OP_ADD   = 11'b10001011000;
   localparam logic [10:0] OP_SUB   = 11'b11001011000;
   localparam logic [10:0] OP_AND   = 11'b10001010000;
   localparam logic [10:0] OP_ORR   = 11'b10101010000;

   localparam logic [1:0] ALU_B_REG     = 2'b00;
   localparam logic [1:0] ALU_B_FOUR    = 2'b01;
   localparam logic [1:0] ALU_B_SEXT    = 2'b10;
   localparam logic [1:0] ALU_B_SEXT_SH = 2'b11;

   localparam logic [1:0] ALU_OP_ADD    = 2'b00;
   localparam logic [1:0] ALU_OP_PASS_B = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

   typedef struct packed {
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic       pc_src;
      logic       mem_read;
      logic       mem_write;
      logic       i_or_d;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg2loc;
      logic       reg_write;
      logic       mem_to_reg;
      logic       halted;
   } ctrl_t;

endpackage

// File: rtl/op_classify.sv
// Combinational decode of the 11-bit opcode field into an instruction class.
module op_classify
   import ctrl_pkg::*;
(
   input  logic [10:0]  op,
   output instr_class_t op_class
);

   always_comb begin
      op_class = CLS_ILLEGAL;
      if (op == OP_LDUR)
         op_class = CLS_LOAD;
      else if (op == OP_STUR)
         op_class = CLS_STORE;
      else if ((op & CBZ_MASK) == OP_CBZ)
         op_class = CLS_CBZ;
      else if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR)
         op_class = CLS_RTYPE;
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 control FSM: per-state datapath strobes, illegal-op trap
// and retired-instruction counter.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int COUNT_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [10:0]        op,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               ir_write,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic               pc_src,
   output logic               mem_read,
   output logic               mem_write,
   output logic               i_or_d,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_op,
   output logic               reg2loc,
   output logic               reg_write,
   output logic               mem_to_reg,
   output logic               halted,
   output logic [3:0]         state_o,
   output logic [COUNT_W-1:0] instr_count
);

   state_t             state_reg, state_next;
   logic               is_load_reg, is_load_next;
   logic [COUNT_W-1:0] count_reg;
   logic               retire;
   instr_class_t       op_class;
   ctrl_t              ctrl_comb, ctrl_out;

   // The zero flag gates pc_write_cond in the datapath, not here.
   logic unused_zero;
   assign unused_zero = zero;

   op_classify u_classify (
      .op       (op),
      .op_class (op_class)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= S_FETCH;
         is_load_reg <= 1'b0;
         count_reg   <= '0;
      end else begin
         state_reg   <= state_next;
         is_load_reg <= is_load_next;
         if (retire)
            count_reg <= count_reg + COUNT_W'(1);
      end
   end

   always_comb begin
      state_next   = state_reg;
      is_load_next = is_load_reg;
      retire       = 1'b0;
      ctrl_comb    = '0;
      case (state_reg)
         S_FETCH: begin
            ctrl_comb.mem_read  = 1'b1;
            ctrl_comb.alu_src_b = ALU_B_FOUR;
            ctrl_comb.alu_op    = ALU_OP_ADD;
            ctrl_comb.ir_write  = mem_ready;
            ctrl_comb.pc_write  = mem_ready;
            if (mem_ready)
               state_next = S_DECODE;
         end
         S_DECODE: begin
            // Opcode is only trusted here; remember load vs store for MEMADR.
            ctrl_comb.alu_src_b = ALU_B_SEXT_SH;
            ctrl_comb.alu_op    = ALU_OP_ADD;
            ctrl_comb.reg2loc   = (op_class == CLS_STORE) || (op_class == CLS_CBZ);
            is_load_next        = (op_class == CLS_LOAD);
            case (op_class)
               CLS_LOAD, CLS_STORE: state_next = S_MEMADR;
               CLS_RTYPE:           state_next = S_EXEC_R;
               CLS_CBZ:             state_next = S_BRANCH;
               default:             state_next = S_HALT;
            endcase
         end
         S_MEMADR: begin
            ctrl_comb.alu_src_a = 1'b1;
            ctrl_comb.alu_src_b = ALU_B_SEXT;
            ctrl_comb.alu_op    = ALU_OP_ADD;
            state_next          = is_load_reg ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            ctrl_comb.mem_read = 1'b1;
            ctrl_comb.i_or_d   = 1'b1;
            if (mem_ready)
               state_next = S_MEMWB;
         end
         S_MEMWB: begin
            ctrl_comb.reg_write  = 1'b1;
            ctrl_comb.mem_to_reg = 1'b1;
            retire               = 1'b1;
            state_next           = S_FETCH;
         end
         S_MEMWRITE: begin
            ctrl_comb.mem_write = 1'b1;
            ctrl_comb.i_or_d    = 1'b1;
            ctrl_comb.reg2loc   = 1'b1;
            if (mem_ready) begin
               retire     = 1'b1;
               state_next = S_FETCH;
            end
         end
         S_EXEC_R: begin
            ctrl_comb.alu_src_a = 1'b1;
            ctrl_comb.alu_src_b = ALU_B_REG;
            ctrl_comb.alu_op    = ALU_OP_FUNCT;
            state_next          = S_ALUWB;
         end
         S_ALUWB: begin
            ctrl_comb.reg_write = 1'b1;
            retire              = 1'b1;
            state_next          = S_FETCH;
         end
         S_BRANCH: begin
            ctrl_comb.reg2loc       = 1'b1;
            ctrl_comb.alu_src_b     = ALU_B_REG;
            ctrl_comb.alu_op        = ALU_OP_PASS_B;
            ctrl_comb.pc_write_cond = 1'b1;
            ctrl_comb.pc_src        = 1'b1;
            retire                  = 1'b1;
            state_next              = S_FETCH;
         end
         S_HALT: begin
            ctrl_comb.halted = 1'b1;
         end
         default: state_next = S_FETCH;
      endcase
   end

   // Reset masks every output combinationally so no strobe escapes in the reset cycle.
   assign ctrl_out      = reset ? '0 : ctrl_comb;
   assign state_o       = reset ? 4'd0 : state_reg;
   assign instr_count   = reset ? '0 : count_reg;

   assign ir_write      = ctrl_out.ir_write;
   assign pc_write      = ctrl_out.pc_write;
   assign pc_write_cond = ctrl_out.pc_write_cond;
   assign pc_src        = ctrl_out.pc_src;
   assign mem_read      = ctrl_out.mem_read;
   assign mem_write     = ctrl_out.mem_write;
   assign i_or_d        = ctrl_out.i_or_d;
   assign alu_src_a     = ctrl_out.alu_src_a;
   assign alu_src_b     = ctrl_out.alu_src_b;
   assign alu_op        = ctrl_out.alu_op;
   assign reg2loc       = ctrl_out.reg2loc;
   assign reg_write     = ctrl_out.reg_write;
   assign mem_to_reg    = ctrl_out.mem_to_reg;
   assign halted        = ctrl_out.halted;

endmodule
